// File: rtl/risc_pkg.sv
// Shared constants for the RISC core: datapath width, PC increment and the
// fetch sequencer state encoding.
package risc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2,
        FETCH_ERR  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO of {instruction, pc} pairs between instruction fetch and decode.
// The head is presented combinationally and holds its last value while empty.
module fetch_buf2
    import risc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_inst,
    input  logic [XLEN-1:0] push_pc,
    output logic [1:0]      count,
    output logic [XLEN-1:0] head_inst,
    output logic [XLEN-1:0] head_pc
);

    logic [XLEN-1:0] inst_q [2];
    logic [XLEN-1:0] pc_q   [2];
    logic            rd_ptr;
    logic            wr_ptr;

    assign head_inst = inst_q[rd_ptr];
    assign head_pc   = pc_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q[0] <= '0;
            inst_q[1] <= '0;
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else if (flush) begin
            // Empty by pulling the write pointer back, so the head outputs stay stable.
            wr_ptr <= rd_ptr;
            count  <= 2'd0;
        end else begin
            if (push) begin
                inst_q[wr_ptr] <= push_inst;
                pc_q[wr_ptr]   <= push_pc;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses inst_mem and buffers opcodes for decode.
// Define IMEM_FETCH_MISALIGN_CHK_EN to trap misaligned redirects into a sticky ERR state.
module imem_fetch_ctrl
    import risc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            busy,
    output logic            misalign_err
);

    localparam logic [1:0] BUF_FULL = 2'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] redirect_target;
    logic [1:0]      count;
    logic            pop;
    logic            push;
    logic            flush;
    logic            redirect_bad;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign imem_addr = fetch_pc;
    assign busy      = (state == FETCH_RUN);

`ifdef IMEM_FETCH_MISALIGN_CHK_EN
    assign redirect_target = redirect_pc;
    assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
    assign misalign_err    = (state == FETCH_ERR);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_bad         = 1'b0;
    assign misalign_err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= pc_nxt;
        end
    end

    // A redirect outranks fetching; a fetch may also refill the slot freed by a same-cycle pop.
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        push      = 1'b0;
        flush     = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (start) state_nxt = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (halt_req) state_nxt = FETCH_HALT;
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_bad) state_nxt = FETCH_ERR;
                    else              pc_nxt    = redirect_target;
                end else if (!halt_req && ((count < BUF_FULL) || pop)) begin
                    push   = 1'b1;
                    pc_nxt = fetch_pc + PC_STEP;
                end
            end
            FETCH_HALT: begin
                if (start && !halt_req) state_nxt = FETCH_RUN;
                if (redirect_valid) begin
                    if (redirect_bad) begin
                        state_nxt = FETCH_ERR;
                        flush     = 1'b1;
                    end else begin
                        pc_nxt = redirect_target;
                    end
                end
            end
            default: begin
                flush = 1'b1;
            end
        endcase
    end

    fetch_buf2 u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_inst (imem_data),
        .push_pc   (fetch_pc),
        .count     (count),
        .head_inst (out_inst),
        .head_pc   (out_pc)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_imem_fetch_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;
    localparam int S_ERR  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        busy;
    logic        misalign_err;

    logic        start2;
    logic        tie0   = 1'b0;
    logic        tie1   = 1'b1;
    logic [31:0] tie32  = 32'd0;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2;
    logic        out_valid2;
    logic [31:0] out_inst2;
    logic [31:0] out_pc2;
    logic        busy2;
    logic        misalign_err2;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [64];
    int          m_state;
    logic [31:0] m_pc;
    logic [63:0] q [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a < 32'd256) return rom[a[7:2]];
        return a ^ 32'hC0DE_1234;
    endfunction

    assign imem_data  = memWord(imem_addr);
    assign imem_data2 = memWord(imem_addr2);

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .busy           (busy),
        .misalign_err   (misalign_err)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .start          (start2),
        .halt_req       (tie0),
        .redirect_valid (tie0),
        .redirect_pc    (tie32),
        .imem_addr      (imem_addr2),
        .imem_data      (imem_data2),
        .out_valid      (out_valid2),
        .out_ready      (tie1),
        .out_inst       (out_inst2),
        .out_pc         (out_pc2),
        .busy           (busy2),
        .misalign_err   (misalign_err2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_pc    = 32'h0;
        m_state = S_IDLE;
    endtask

    // One clock of the reference: pops first, then the state-dependent fetch or redirect.
    task automatic modelStep();
        int   ns;
        logic mis;
        ns = m_state;
`ifdef IMEM_FETCH_MISALIGN_CHK_EN
        mis = (redirect_pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        case (m_state)
            S_IDLE: if (start) ns = S_RUN;
            S_RUN: begin
                if (halt_req) ns = S_HALT;
                if (redirect_valid) begin
                    q.delete();
                    if (mis) ns = S_ERR;
                    else     m_pc = redirect_pc & 32'hFFFF_FFFC;
                end else if (!halt_req && q.size() < 2) begin
                    q.push_back({memWord(m_pc), m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
            S_HALT: begin
                if (start && !halt_req) ns = S_RUN;
                if (redirect_valid) begin
                    if (mis) begin
                        ns = S_ERR;
                        q.delete();
                    end else begin
                        m_pc = redirect_pc & 32'hFFFF_FFFC;
                    end
                end
            end
            default: q.delete();
        endcase
        m_state = ns;
    endtask

    task automatic modelCheck();
        checkOutput("valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            checkOutput("head_pc", out_pc, q[0][31:0]);
            checkOutput("head_inst", out_inst, q[0][63:32]);
        end
        checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("busy", {31'b0, busy}, {31'b0, m_state == S_RUN});
        checkOutput("misalign", {31'b0, misalign_err}, {31'b0, m_state == S_ERR});
    endtask

    // Drive one cycle of inputs at the falling edge, then clock and compare with the model.
    task automatic applyStimulus(input logic st, input logic hr, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        start          = st;
        halt_req       = hr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        modelStep();
        #1;
        modelCheck();
        @(negedge clk);
    endtask

    task automatic resetDut();
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        reset          = 1'b1;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic        st;
        logic        hr;
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;

        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        reset = 1'b1; start = 1'b0; start2 = 1'b0; halt_req = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_inst", out_inst, 32'd0);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] streaming with out_ready high");
        start2 = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        start2 = 1'b0;
        checkOutput("start_busy", {31'b0, busy}, 32'd1);
        checkOutput("start_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("stream_pc", out_pc, 32'(4 * i));
            checkOutput("stream_inst", out_inst, rom[i]);
            if (i < 3) begin
                checkOutput("wrap_valid", {31'b0, out_valid2}, 32'd1);
                checkOutput("wrap_pc", out_pc2, 32'hFFFF_FFF8 + 32'(4 * i));
            end
        end

        $display("[TB] back-pressure");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("bp_addr", imem_addr, 32'h8);
        checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_head", out_pc, 32'(4 * k));
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end

        $display("[TB] redirect with two entries buffered");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir_pre_head", out_pc, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("redir_bubble", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redir_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("redir_pc0", out_pc, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir_pc1", out_pc, 32'h44);

        $display("[TB] halt drains the buffer");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("halt_busy", {31'b0, busy}, 32'd0);
        checkOutput("halt_head", out_pc, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("halt_empty", {31'b0, out_valid}, 32'd0);
            checkOutput("halt_addr", imem_addr, 32'h8);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("resume_busy", {31'b0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("resume_pc", out_pc, 32'h8);

        $display("[TB] misaligned redirect");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h42, 1'b1);
        checkOutput("mis_bubble", {31'b0, out_valid}, 32'd0);
`ifdef IMEM_FETCH_MISALIGN_CHK_EN
        checkOutput("mis_flag", {31'b0, misalign_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("err_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("err_flag", {31'b0, misalign_err}, 32'd1);
        end
`else
        checkOutput("mis_flag", {31'b0, misalign_err}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mis_pc0", out_pc, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mis_pc1", out_pc, 32'h44);
`endif
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_addr", imem_addr, 32'h0);
        checkOutput("async_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("async_valid", {31'b0, out_valid}, 32'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] randomized traffic");
        hr = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ((n % 160) == 159 || m_state == S_ERR && $urandom_range(0, 3) == 0) resetDut();
            st  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) hr = ~hr;
            rv  = (m_state != S_HALT) && ($urandom_range(0, 7) == 0);
            rpc = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(st, hr, rv, rpc, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the combinational instruction memory (`inst_mem`, address `PC` to `op_code`). It owns the program counter, drives the memory address, and captures returned opcodes into a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. It also handles start/halt control and branch/jump redirects, and sits between `inst_mem` and the decode stage of the RISC core.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, default 2: instruction buffer depth. Fixed at 2; other values are unsupported.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: pulse; leaves IDLE or HALT and begins fetching.
- `halt_req`, in, 1: level; stops issuing fetches.
- `redirect_valid`, in, 1: branch/jump taken.
- `redirect_pc`, in, 32: target address.
- `imem_addr`, out, 32: drives `inst_mem.PC`.
- `imem_data`, in, 32: from `inst_mem.op_code`.
- `out_valid`, out, 1: buffer head valid.
- `out_ready`, in, 1: decode accepts the head.
- `out_inst`, out, 32: head opcode.
- `out_pc`, out, 32: PC of the head opcode.
- `busy`, out, 1: high in RUN.
- `misalign_err`, out, 1: sticky error flag. Tied 0 unless the macro is enabled.

## Operation
- FSM states: IDLE, RUN, HALT (plus ERR when the macro is enabled).
  - IDLE -> RUN on `start`.
  - RUN -> HALT on `halt_req`.
  - HALT -> RUN on `start` with `halt_req` low.
  - `start` while `halt_req` is high stays in HALT.
- `imem_addr` = the `fetch_pc` register, combinational from state. It is valid in all states.
- Fetch fires in RUN when `count < 2`, or when `count == 2` and a pop occurs the same cycle. On fire: write {`imem_data`, `fetch_pc`} into the tail, then `fetch_pc <= fetch_pc + 4`.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Pop occurs when `out_valid && out_ready`. The head advances and `count` decrements, unless a fetch also fires that cycle, in which case `count` is unchanged.
- Redirect (any state except IDLE/ERR) has the highest priority:
  - Flush the buffer (`count <= 0`) and set `fetch_pc <= redirect_pc`.
  - A same-cycle fetch is discarded. A same-cycle pop still counts as consumed.
  - In HALT, a redirect updates the PC only.
- HALT: no fetches. The buffer continues to drain via pops. `fetch_pc` holds.
- `out_inst`/`out_pc` are undefined-but-stable (hold the last head) when `out_valid` is 0.

## Timing
- Reset values:
  - `fetch_pc` = `RESET_PC`, `imem_addr` = `RESET_PC`.
  - `count` = 0, `out_valid` = 0, `out_inst` = 0, `out_pc` = 0.
  - State = IDLE, `busy` = 0, `misalign_err` = 0.
- `start` at edge N: state is RUN after N. The first fetch is captured at edge N+1 and `out_valid` = 1 after N+1.
- Throughput: with `out_ready` held high, one instruction per cycle.
- Back-pressure: with `out_ready` low, the buffer fills after 2 fetches and `fetch_pc` stops advancing.
- Redirect at edge R: `out_valid` = 0 after R. The target instruction is captured at R+1 and valid after R+1, so there is a 1-cycle bubble.
- Reset asserted mid-operation clears everything immediately, asynchronously. No output glitch-hold is required.

## Configuration
- Macro: `IMEM_FETCH_MISALIGN_CHK_EN`.
- Enabled:
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign_err` and moves to ERR.
  - ERR does no fetches, flushes the buffer, and holds `fetch_pc`. It is left only by `reset`.
- Disabled:
  - `redirect_pc[1:0]` is forced to 0 on load.
  - `misalign_err` is tied 0 and there is no ERR state.

## Structure
- Shared package `risc_pkg`: FSM state encoding (`FETCH_IDLE`/`FETCH_RUN`/`FETCH_HALT`/`FETCH_ERR`), `PC_STEP` = 4, and the `XLEN` = 32 constant.
- One sub-module: `fetch_buf2`, a 2-entry FIFO of {inst, pc} with push/pop/flush and count, instantiated once.

## Test plan
- Reset, then `start`, `out_ready` = 1, with memory preloaded with words at 0..28: `out_pc` runs 0,4,8,…,28 on consecutive cycles, and each `out_inst` matches `inst_mem` at that address.
- Hold `out_ready` = 0 after 1 fetch: `count` = 2, `imem_addr` freezes at 8. Release: pops return PC 0, then 4, then 8, with no loss or duplication.
- Redirect to 0x40 while the buffer holds PCs 4 and 8: `out_valid` = 0 for 1 cycle, then `out_pc` = 0x40, 0x44.
- `halt_req` in RUN with 2 entries buffered: the 2 entries drain, no new fetch occurs, and `busy` = 0. `start` with `halt_req` low resumes at the held PC.
- `RESET_PC` = 0xFFFF_FFF8, `start`: `out_pc` sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Macro on, redirect to 0x42: `misalign_err` = 1, `out_valid` = 0 thereafter. Asynchronous `reset` clears it to IDLE with `imem_addr` = `RESET_PC`. Macro off: the same stimulus fetches at 0x40.
